// File: rtl/proj2_host_pkg.sv
// Shared types and constants for the Proj2 host-side sequencer.
package proj2_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        WAIT_HI,
        WAIT_LO,
        READ,
        RESP
    } state_e;

    localparam logic [1:0] REG_A0 = 2'd0;
    localparam logic [1:0] REG_A1 = 2'd1;
    localparam logic [1:0] REG_A2 = 2'd2;
    localparam logic [1:0] REG_A3 = 2'd3;

    localparam int unsigned BYTES_PER_REG = 32;
    localparam int unsigned LOAD_BYTES    = 96;

endpackage

// File: rtl/proj2_host.sv
// Sequencer: streams a1..a3 into the Proj2 core byte by byte, launches it,
// waits for completion and reads a0 back onto a valid/ready response channel.
module proj2_host
    import proj2_host_pkg::*;
#(
    parameter int unsigned TIMEOUT = 2**20,
    parameter int unsigned BYTES   = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [255:0] cmd_a1,
    input  logic [255:0] cmd_a2,
    input  logic [255:0] cmd_a3,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [255:0] rsp_a0,
    output logic         rsp_err,
    output logic         p2_we,
    output logic         p2_oe,
    output logic         p2_start,
    output logic [1:0]   p2_reg_sel,
    output logic [4:0]   p2_addr,
    output logic [7:0]   p2_data,
    input  logic [7:0]   p2_rdata,
    input  logic         p2_ready
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    state_e         state_q, state_d;
    logic [6:0]     k_q, k_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [767:0]   ops_q, ops_d;
    logic [255:0]   res_q, res_d;
    logic           err_q, err_d;

    logic           we_q, we_d;
    logic           oe_q, oe_d;
    logic           start_q, start_d;
    logic [1:0]     sel_q, sel_d;
    logic [4:0]     addr_q, addr_d;
    logic [7:0]     data_q, data_d;

    assign cmd_ready  = (state_q == IDLE) && !p2_ready && !reset;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_a0     = res_q;
    assign rsp_err    = err_q;
    assign p2_we      = we_q;
    assign p2_oe      = oe_q;
    assign p2_start   = start_q;
    assign p2_reg_sel = sel_q;
    assign p2_addr    = addr_q;
    assign p2_data    = data_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tmr_d   = tmr_q;
        ops_d   = ops_q;
        res_d   = res_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    ops_d   = {cmd_a3, cmd_a2, cmd_a1};
                    k_d     = '0;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (k_q == 7'(LOAD_BYTES - 1)) state_d = LAUNCH;
                else                           k_d     = k_q + 7'd1;
            end
            LAUNCH: begin
                tmr_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (p2_ready) begin
                    tmr_d   = '0;
                    state_d = WAIT_LO;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!p2_ready) begin
                    k_d     = '0;
                    state_d = READ;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            READ: begin
                // p2_addr_q tracks k_q here, so p2_rdata is byte k_q this cycle
                res_d[{k_q[4:0], 3'b000} +: 8] = p2_rdata;
                if (k_q == 7'(BYTES - 1)) state_d = RESP;
                else                      k_d     = k_q + 7'd1;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin values are derived from the next state so every p2_* is a flop output.
    always_comb begin
        we_d    = (state_d == LOAD);
        oe_d    = (state_d == READ);
        start_d = (state_d != LAUNCH);
        sel_d   = REG_A0;
        addr_d  = '0;
        data_d  = '0;
        if (state_d == LOAD) begin
            sel_d  = k_d[6:5] + REG_A1;
            addr_d = k_d[4:0];
            data_d = ops_d[{k_d, 3'b000} +: 8];
        end else if (state_d == READ) begin
            addr_d = k_d[4:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            tmr_q   <= '0;
            ops_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            start_q <= 1'b1;
            sel_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tmr_q   <= tmr_d;
            ops_q   <= ops_d;
            res_q   <= res_d;
            err_q   <= err_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            start_q <= start_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_proj2_host.sv
// Bench for proj2_host with a behavioural Proj2 core model.
// Core model: a0 = a1 ^ a2 ^ a3 ^ 'hDEADBEEF; busy for delay+1 cycles after launch.
module proj2_core_model (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  int         delay,
    input  int         mode,      // 0 normal, 1 never raises ready, 2 never drops ready
    input  logic       we,
    input  logic       oe,
    input  logic       start,
    input  logic [1:0] reg_sel,
    input  logic [4:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ready
);
    logic [7:0]   regs [4][32];
    logic [255:0] key;
    int           cnt, wr_cnt, wr_bad, start_lo;

    assign key   = 256'hDEAD_BEEF;
    assign rdata = oe ? regs[reg_sel][addr] : 8'h00;

    always @(posedge clk) begin
        if (clr) begin
            wr_cnt   <= 0;
            wr_bad   <= 0;
            start_lo <= 0;
        end else begin
            if (we && !ready) begin
                regs[reg_sel][addr] <= wdata;
                if (reg_sel != 2'(wr_cnt / 32 + 1) || addr != 5'(wr_cnt % 32))
                    wr_bad <= wr_bad + 1;
                wr_cnt <= wr_cnt + 1;
            end
            if (!start) start_lo <= start_lo + 1;
        end
        if (rst) begin
            ready <= 1'b0;
            cnt   <= 0;
        end else if (!ready && !we && !oe && !start) begin
            if (mode != 1) begin
                ready <= 1'b1;
                cnt   <= delay;
                for (int i = 0; i < 32; i++)
                    regs[0][i] <= regs[1][i] ^ regs[2][i] ^ regs[3][i] ^ key[8*i +: 8];
            end
        end else if (ready && mode != 2) begin
            if (cnt == 0) ready <= 1'b0;
            else          cnt   <= cnt - 1;
        end
    end
endmodule

module tb_proj2_host;
    localparam int unsigned TO = 16;
    localparam logic [255:0] KEY = 256'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid, cmd_ready;
    logic [255:0] cmd_a1, cmd_a2, cmd_a3;
    logic         rsp_valid, rsp_ready, rsp_err;
    logic [255:0] rsp_a0;
    logic         p2_we, p2_oe, p2_start, p2_ready;
    logic [1:0]   p2_reg_sel;
    logic [4:0]   p2_addr;
    logic [7:0]   p2_data, p2_rdata;
    logic         mclr;
    int           model_delay, model_mode;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_rsp = 0;
    int n_launch = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    proj2_host #(.TIMEOUT(TO), .BYTES(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a1(cmd_a1), .cmd_a2(cmd_a2), .cmd_a3(cmd_a3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a0(rsp_a0), .rsp_err(rsp_err),
        .p2_we(p2_we), .p2_oe(p2_oe), .p2_start(p2_start),
        .p2_reg_sel(p2_reg_sel), .p2_addr(p2_addr), .p2_data(p2_data),
        .p2_rdata(p2_rdata), .p2_ready(p2_ready)
    );

    proj2_core_model u_core (
        .clk(clk), .rst(reset), .clr(mclr), .delay(model_delay), .mode(model_mode),
        .we(p2_we), .oe(p2_oe), .start(p2_start), .reg_sel(p2_reg_sel),
        .addr(p2_addr), .wdata(p2_data), .rdata(p2_rdata), .ready(p2_ready)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every launch must follow completion of all earlier responses.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) n_rsp++;
        if (!p2_start) begin
            check("launch_order", n_rsp, n_launch);
            n_launch++;
        end
    end

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic pulse_clr();
        mclr = 1'b1;
        @(negedge clk);
        mclr = 1'b0;
    endtask

    task automatic run_cmd(input logic [255:0] a1, input logic [255:0] a2, input logic [255:0] a3,
                           input int dly, input int mode, input int hold);
        logic [255:0] exp_a0, held;
        logic         exp_err;
        int           exp_lat, hs, n;
        bit           stable;
        if (mode == 0) begin
            exp_a0  = a1 ^ a2 ^ a3 ^ KEY;
            exp_err = 1'b0;
            exp_lat = 96 + 1 + 32 + 1 + (1 + dly + 1);
        end else if (mode == 1) begin
            exp_a0  = '0;
            exp_err = 1'b1;
            exp_lat = 96 + 1 + TO + 1;
        end else begin
            exp_a0  = '0;
            exp_err = 1'b1;
            exp_lat = 96 + 1 + 1 + TO + 1;
        end
        model_delay = dly;
        model_mode  = mode;
        pulse_clr();
        cmd_a1 = a1; cmd_a2 = a2; cmd_a3 = a3;
        cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        check("cmd_accept", cmd_ready, 1'b1);
        if (!cmd_ready) begin cmd_valid = 1'b0; return; end
        hs = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
        check("rsp_seen", rsp_valid, 1'b1);
        check("latency", cyc - hs, exp_lat);
        check("rsp_a0", rsp_a0, exp_a0);
        check("rsp_err", rsp_err, exp_err);
        check("write_count", u_core.wr_cnt, 96);
        check("write_order", u_core.wr_bad, 0);
        check("start_low_cycles", u_core.start_lo, 1);
        if (hold > 0) begin
            held = rsp_a0;
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!rsp_valid || rsp_a0 !== held || cmd_ready) stable = 1'b0;
            end
            check("hold_stable", stable, 1'b1);
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("rsp_drop", rsp_valid, 1'b0);
        if (mode == 2) begin
            check("busy_blocks_cmd", cmd_ready, 1'b0);
            model_mode = 0;
            @(negedge clk);
        end
        check("idle_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        logic [255:0] a3b;
        int n;
        reset = 1'b1;
        cmd_valid = 1'b0; rsp_ready = 1'b0; mclr = 1'b0;
        cmd_a1 = '0; cmd_a2 = '0; cmd_a3 = '0;
        model_delay = 0; model_mode = 0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_a0", rsp_a0, '0);
        check("rst_pins", {p2_we, p2_oe, p2_start, p2_reg_sel, p2_addr, p2_data}, {1'b0, 1'b0, 1'b1, 15'd0});
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1'b1);

        // basic run: a0 comes back as DEADBEEF, 142-cycle latency
        run_cmd(256'h01, 256'h02, 256'h03, 10, 0, 0);

        // byte ordering in register 3
        for (int i = 0; i < 32; i++) a3b[255 - 8*i -: 8] = 8'(i);
        run_cmd(rand256(), rand256(), a3b, 0, 0, 0);
        for (int k = 0; k < 32; k++) check("byte_order", u_core.regs[3][k], 8'(31 - k));

        // backpressure
        run_cmd(rand256(), rand256(), rand256(), 5, 0, 50);

        // timeouts in WAIT_HI and WAIT_LO
        run_cmd(rand256(), rand256(), rand256(), 0, 1, 0);
        run_cmd(rand256(), rand256(), rand256(), 0, 2, 3);

        // reset while loading byte 40
        model_mode = 0;
        model_delay = 3;
        pulse_clr();
        cmd_a1 = rand256(); cmd_a2 = rand256(); cmd_a3 = rand256();
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (u_core.wr_cnt < 40 && n < 200) begin @(negedge clk); n++; end
        check("reach_byte40", u_core.wr_cnt, 40);
        reset = 1'b1;
        #1;
        check("midrst_we", p2_we, 1'b0);
        check("midrst_start", p2_start, 1'b1);
        check("midrst_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rel_cmd_ready", cmd_ready, 1'b1);
        run_cmd(rand256(), rand256(), rand256(), 2, 0, 0);

        // back-to-back with rsp_ready held high
        run_cmd(rand256(), rand256(), rand256(), 1, 0, 0);
        run_cmd(rand256(), rand256(), rand256(), 4, 0, 0);

        // randomized commands
        repeat (10)
            run_cmd(rand256(), rand256(), rand256(), int'($urandom_range(0, 12)), 0,
                    int'($urandom_range(0, 3)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
